// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Halt state machine: normal execution, draining after HALT, fully halted.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  // Default register-address width.
  localparam int REG_W_DEFAULT = 5;

  // Register 0 is hard-wired zero, so it never creates a load-use dependency.
  localparam logic [REG_W_DEFAULT-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_halt_fsm.sv
// Halt/drain/resume state machine: state register, drain counter, registered
// enable_halt/halted. Latency: outputs change one cycle after the triggering input.
// Backpressure: memwait_i freezes state and drain counter.
// Ports: clk, reset (sync, active-high), accept_halt_i (HALT leaves D),
//        memwait_i (data memory stalling), resume_i (restart pulse),
//        state_o (current state), enable_halt_o (fetch freeze), halted_o (drained).
module halt_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_halt_i,
  input  logic        memwait_i,
  input  logic        resume_i,
  output halt_state_t state_o,
  output logic        enable_halt_o,
  output logic        halted_o
);

  localparam int CW = $clog2(DRAIN_CYC + 1);

  halt_state_t   state_q;
  logic [CW-1:0] drain_cnt_q;
  logic          enable_halt_q;
  logic          halted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      enable_halt_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept_halt_i) begin
            state_q       <= DRAIN;
            drain_cnt_q   <= CW'(DRAIN_CYC);
            enable_halt_q <= 1'b1;
          end
        end
        DRAIN: begin
          // Memory wait cycles do not advance the pipeline, so they do not count.
          if (!memwait_i) begin
            if (drain_cnt_q == CW'(1)) begin
              state_q     <= HALTED;
              drain_cnt_q <= '0;
              halted_q    <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q - CW'(1);
            end
          end
        end
        HALTED: begin
          if (resume_i && !memwait_i) begin
            state_q       <= RUN;
            enable_halt_q <= 1'b0;
            halted_q      <= 1'b0;
          end
        end
        default: begin
          state_q       <= RUN;
          drain_cnt_q   <= '0;
          enable_halt_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign state_o       = state_q;
  assign enable_halt_o = enable_halt_q;
  assign halted_o      = halted_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush/halt control with saturating stall and flush counters.
// Latency: stalls/flushes combinational (same cycle); enable_halt/halted registered.
// Backpressure: data-memory wait stalls every stage and freezes the halt FSM.
// Ports: hazard inputs from D/E/M stages, resume pulse; per-register stall/flush
//        controls, enable_halt/halted status, stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W     = REG_W_DEFAULT,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rt_e,
  input  logic             memtoreg_e,
  input  logic             pcsrc_e,
  input  logic             halt_d,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  input  logic             resume,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             enable_halt,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic        memwait;
  logic        lu;
  logic        in_run;
  logic        in_halted;
  logic        accept_halt;
  halt_state_t state;
  logic        fsm_enable_halt;
  logic        fsm_halted;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign memwait   = mem_req_m & ~mem_ready_m;
  assign lu        = memtoreg_e & (rt_e != REG_W'(REG_ZERO)) &
                     ((rt_e == rs_d) | (rt_e == rt_d));
  assign in_run    = (state == RUN);
  assign in_halted = (state == HALTED);

  // A HALT is taken only when it is neither squashed nor waiting on a load.
  assign accept_halt = in_run & halt_d & ~memwait & ~pcsrc_e & ~lu;

  halt_fsm #(
    .DRAIN_CYC (DRAIN_CYC)
  ) u_halt_fsm (
    .clk           (clk),
    .reset         (reset),
    .accept_halt_i (accept_halt),
    .memwait_i     (memwait),
    .resume_i      (resume),
    .state_o       (state),
    .enable_halt_o (fsm_enable_halt),
    .halted_o      (fsm_halted)
  );

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!reset) begin
      if (memwait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else begin
        // Once draining, no older branch remains in E, so pcsrc_e only matters in RUN.
        if (in_run && pcsrc_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lu) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        // Fetch is frozen: feed bubbles into D while draining or halted.
        if (!in_run) flush_d = 1'b1;
      end
    end
  end

  assign enable_halt = fsm_enable_halt & ~reset;
  assign halted      = fsm_halted & ~reset;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!in_halted) begin
      if (stall_f && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((flush_d || flush_e) && flush_cnt_q != {CNT_W{1'b1}})
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control block that produces the stall, flush and halt-enable signals consumed by every pipeline register (PC and F/D, D/E, E/M registers). It is the driving end of the register stall/halt interface.
- Detects load-use hazards, taken-branch squashes and data-memory wait states.
- Runs the halt/drain/resume state machine that freezes fetch on a HALT instruction.
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_W, 5, register-address width.
- DRAIN_CYC, 3, cycles after HALT leaves D until the pipeline counts as drained.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rs_d  input  REG_W  source reg 1 of the instruction in D.
- rt_d  input  REG_W  source reg 2 of the instruction in D.
- rt_e  input  REG_W  destination of the instruction in E.
- memtoreg_e  input  1  instruction in E is a load.
- pcsrc_e  input  1  branch taken, resolved in E.
- halt_d  input  1  instruction in D is HALT.
- mem_req_m  input  1  data-memory access in M.
- mem_ready_m  input  1  data memory completes this cycle.
- resume  input  1  restart pulse, honoured only in HALTED.
- stall_f  output  1  hold the PC register.
- stall_d  output  1  hold the F/D register.
- stall_e  output  1  hold the D/E register.
- stall_m  output  1  hold the E/M register.
- flush_d  output  1  bubble into the F/D register.
- flush_e  output  1  bubble into the D/E register.
- enable_halt  output  1  fetch freeze to the PC register.
- halted  output  1  pipeline drained and idle.
- stall_cnt  output  CNT_W  cycles with stall_f=1.
- flush_cnt  output  CNT_W  cycles with flush_d or flush_e =1.

Behaviour:
- All state updates on posedge clk. reset is synchronous; when sampled high, on the next edge: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0.
- While reset=1, all stall/flush outputs, enable_halt and halted are forced to 0.
- Stall/flush outputs are combinational from the inputs and state, effective the same cycle (zero latency). enable_halt and halted decode the registered state only.
- memwait = mem_req_m & !mem_ready_m.
- lu = memtoreg_e & (rt_e!=0) & (rt_e==rs_d | rt_e==rt_d).
- Priority 1, memwait: stall_f, stall_d, stall_e, stall_m =1. No flushes. FSM and drain counter frozen.
- Priority 2, pcsrc_e (RUN only): flush_d=1, flush_e=1. lu and halt_d are ignored because the D instruction is squashed.
- Priority 3, lu: stall_f=1, stall_d=1, flush_e=1. A HALT in D is not accepted while lu=1.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN when halt_d & !memwait & !pcsrc_e & !lu. Drain counter loads DRAIN_CYC.
  - DRAIN: enable_halt=1 and flush_d=1 every cycle. pcsrc_e is ignored, since no older branch can still be in E. The counter decrements on each non-memwait cycle. At counter==1 with a decrement, go to HALTED.
  - HALTED: enable_halt=1, halted=1, flush_d=1. When resume=1 (and not reset), go to RUN; enable_halt drops the following cycle.
  - resume outside HALTED has no effect.
- Counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap). They are frozen in HALTED.
- Reset mid-DRAIN or mid-memwait: the FSM returns to RUN next edge with counters cleared. No residual stall.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum halt_state_t {RUN, DRAIN, HALTED};
  - REG_W default;
  - localparam REG_ZERO.
- One sub-module, halt_fsm: state register, drain counter, enable_halt, halted. Inputs are accept_halt, memwait and resume.
- Hazard priority logic and counters stay in the top module.

Test Plan:
- Load-use: memtoreg_e=1, rt_e=5, rs_d=5, no other events -> stall_f=stall_d=flush_e=1 that cycle. With rt_e=0 the same stimulus gives all outputs 0.
- Branch beats load-use: pcsrc_e=1 with the lu condition also true -> flush_d=flush_e=1, stall_f=0. stall_cnt unchanged, flush_cnt +1.
- Memwait: mem_req_m=1, mem_ready_m=0 for 4 cycles, with pcsrc_e=1 concurrently -> all four stalls=1 and flushes=0 for 4 cycles. stall_cnt +4.
- Halt: halt_d=1 in RUN -> next cycle enable_halt=1. halted=1 exactly DRAIN_CYC=3 cycles later. A 2-cycle memwait inside DRAIN delays halted by 2. resume pulse -> RUN, enable_halt=0 one cycle later.
- Halt squashed: halt_d=1 with pcsrc_e=1 -> stays in RUN, enable_halt stays 0.
- Reset mid-DRAIN, and saturation: reset=1 for 1 cycle in DRAIN -> RUN, counters 0, outputs 0. Preloading stall_cnt to 16'hFFFF via 65535 stall cycles, one more stall -> stall_cnt stays 16'hFFFF.
